spi_slave_regfile: RTL and testbench

//  SPI mode-0 slave register file: the far end of the picoblaze bit-banged SPI master
//  (spi_cs/spi_clk/spi_sdi out, spi_sdo in, MSB first). Sits on the peripheral board.

---
 rtl/spi_slave_regfile.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave register file: ID/sensor/RW byte registers behind a synchronized SPI port.
// Define SPI_WR_PULSE_EN to get the wr_pulse/wr_addr/wr_data commit strobe; otherwise those outputs are tied to 0.
//   state   | meaning
//   IDLE    | cs high, waiting for a cs fall
//   CMD     | shifting in byte0 {rw, addr}
//   DATA    | shifting data bytes, address auto-increments
//   WAIT_CS | reset hit mid-frame, ignore the bus until cs rises
module spi_slave_regfile #(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] DEVICE_ID   = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      spi_cs_i,
  input  logic                      spi_clk_i,
  input  logic                      spi_sdi_i,
  output logic                      spi_sdo_o,
  input  logic [7:0]                sensor_i,
  output logic [(NUM_REGS-2)*8-1:0] reg_out_o,
  output logic                      frame_active_o,
  output logic                      wr_pulse_o,
  output logic [6:0]                wr_addr_o,
  output logic [7:0]                wr_data_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_WAIT_CS} state_t;

  state_t state_q, state_d;

  // Synchronizers carry no reset so a cs already low at reset release is seen as low, not as a fall.
  logic [SYNC_STAGES:0]   cs_pipe_q;
  logic [SYNC_STAGES:0]   sclk_pipe_q;
  logic [SYNC_STAGES-1:0] sdi_pipe_q;

  always_ff @(posedge clk_i) begin
    cs_pipe_q   <= {cs_pipe_q[SYNC_STAGES-1:0], spi_cs_i};
    sclk_pipe_q <= {sclk_pipe_q[SYNC_STAGES-1:0], spi_clk_i};
    sdi_pipe_q  <= {sdi_pipe_q[SYNC_STAGES-2:0], spi_sdi_i};
  end

  logic cs_s, sdi_s, cs_rise, cs_fall, sclk_rise, sclk_fall;

  assign cs_s      = cs_pipe_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_pipe_q[SYNC_STAGES-1];
  assign cs_fall   =  cs_pipe_q[SYNC_STAGES]   & ~cs_pipe_q[SYNC_STAGES-1];
  assign cs_rise   = ~cs_pipe_q[SYNC_STAGES]   &  cs_pipe_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_pipe_q[SYNC_STAGES] &  sclk_pipe_q[SYNC_STAGES-1];
  assign sclk_fall =  sclk_pipe_q[SYNC_STAGES] & ~sclk_pipe_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_in_q, shift_in_d;
  logic [7:0] sdo_sr_q, sdo_sr_d;
  logic       sdo_q, sdo_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [(NUM_REGS-2)*8-1:0] reg_out_q, reg_out_d;

  logic       active, rise_ok, byte_done, cmd_done, data_done, load, wr_en;
  logic [7:0] rx_byte, rd_data;
  logic [6:0] rd_addr;

  assign active    = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign rise_ok   = active && sclk_rise && !cs_rise;
  assign byte_done = rise_ok && (bit_cnt_q == 3'd7);
  assign cmd_done  = byte_done && (state_q == ST_CMD);
  assign data_done = byte_done && (state_q == ST_DATA);
  assign rx_byte   = {shift_in_q[6:0], sdi_s};
  assign rd_addr   = cmd_done ? rx_byte[6:0] : addr_q + 7'd1;
  assign load      = (cmd_done && rx_byte[7]) || (data_done && rw_q);
  assign wr_en     = data_done && !rw_q && (addr_q >= 7'd2) && ({1'b0, addr_q} < 8'(NUM_REGS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cs_fall) state_d = ST_CMD;
                  else if (!cs_s) state_d = ST_WAIT_CS;
      ST_CMD:     if (cs_rise) state_d = ST_IDLE;
                  else if (cmd_done) state_d = ST_DATA;
      ST_DATA:    if (cs_rise) state_d = ST_IDLE;
      ST_WAIT_CS: if (cs_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == 7'd0) begin
      rd_data = DEVICE_ID;
    end else if (rd_addr == 7'd1) begin
      rd_data = sensor_i;
    end else begin
      for (int k = 2; k < NUM_REGS; k++) begin
        if (rd_addr == 7'(k)) rd_data = reg_out_q[(k-2)*8 +: 8];
      end
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_in_d = shift_in_q;
    sdo_sr_d   = sdo_sr_q;
    sdo_d      = sdo_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    reg_out_d  = reg_out_q;

    if (!active || cs_rise) begin
      bit_cnt_d = 3'd0;
    end else if (rise_ok) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      shift_in_d = rx_byte;
    end

    if (cmd_done) begin
      rw_d   = rx_byte[7];
      addr_d = rx_byte[6:0];
    end else if (data_done) begin
      addr_d = addr_q + 7'd1;
    end

    for (int k = 2; k < NUM_REGS; k++) begin
      if (wr_en && addr_q == 7'(k)) reg_out_d[(k-2)*8 +: 8] = rx_byte;
    end

    // The fall right after a byte's 8th rise (bit_cnt wrapped to 0) must not shift the freshly loaded byte.
    if (cs_rise) begin
      sdo_sr_d = 8'h00;
      sdo_d    = 1'b0;
    end else if (load) begin
      sdo_sr_d = rd_data;
      sdo_d    = rd_data[7];
    end else if (data_done || state_q != ST_DATA) begin
      sdo_sr_d = 8'h00;
      sdo_d    = 1'b0;
    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
      sdo_sr_d = {sdo_sr_q[6:0], 1'b0};
      sdo_d    = sdo_sr_q[6];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_cnt_q  <= 3'd0;
      shift_in_q <= 8'h00;
      sdo_sr_q   <= 8'h00;
      sdo_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      reg_out_q  <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_in_q <= shift_in_d;
      sdo_sr_q   <= sdo_sr_d;
      sdo_q      <= sdo_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      reg_out_q  <= reg_out_d;
    end
  end

  assign spi_sdo_o      = sdo_q;
  assign reg_out_o      = reg_out_q;
  assign frame_active_o = active;

`ifdef SPI_WR_PULSE_EN
  logic       wr_pulse_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'h00;
    end else begin
      wr_pulse_q <= wr_en;
      if (wr_en) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  assign wr_pulse_o = wr_pulse_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
`else
  assign wr_pulse_o = 1'b0;
  assign wr_addr_o  = 7'd0;
  assign wr_data_o  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: table of SPI frames with expected MISO/reg_out, plus partial-frame and reset-mid-frame sequences.
module tb_spi_slave_regfile;
  localparam int NUM_REGS = 8;
  localparam int HALF     = 8;
`ifdef SPI_WR_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, spi_cs, spi_clk, spi_sdi, spi_sdo;
  logic [7:0]  sensor;
  logic [47:0] reg_out;
  logic        frame_active, wr_pulse;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  spi_slave_regfile #(.NUM_REGS(NUM_REGS), .DEVICE_ID(8'hA5), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset), .spi_cs_i(spi_cs), .spi_clk_i(spi_clk), .spi_sdi_i(spi_sdi),
    .spi_sdo_o(spi_sdo), .sensor_i(sensor), .reg_out_o(reg_out), .frame_active_o(frame_active),
    .wr_pulse_o(wr_pulse), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  n;
    logic [23:0] data;
    logic [7:0]  sensor;
    logic [23:0] exp;
    logic [47:0] reg_exp;
    logic [3:0]  pulses;
    logic [6:0]  wa;
    logic [7:0]  wd;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int change_cyc = 0;
  int pulse_cnt = 0;
  logic [47:0] prev_reg = '0;
  logic [7:0]  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) pulse_cnt++;
    if (reg_out !== prev_reg) change_cyc = cyc;
    prev_reg = reg_out;
  end

  initial begin
    #800us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic s);
    spi_sdi = b;
    repeat (HALF) @(negedge clk);
    s = spi_sdo;
    spi_clk = 1'b1;
    last_rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] rx, e;
    int p0;
    sensor = v.sensor;
    p0 = pulse_cnt;
    cs_low();
    spi_byte(v.cmd, rx);
    chk($sformatf("v%0d_cmd_sdo", idx), rx, 8'h00);
    for (int i = 0; i < int'(v.n); i++) begin
      exp_q.push_back(v.exp[23-8*i -: 8]);
      spi_byte(v.data[23-8*i -: 8], rx);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_miso%0d", idx, i), rx, e);
    end
    cs_high();
    chk($sformatf("v%0d_reg_out", idx), reg_out, v.reg_exp);
    chk($sformatf("v%0d_pulses", idx), pulse_cnt - p0, PULSE_EN ? int'(v.pulses) : 0);
    chk($sformatf("v%0d_wr_addr", idx), wr_addr, PULSE_EN ? v.wa : 7'd0);
    chk($sformatf("v%0d_wr_data", idx), wr_data, PULSE_EN ? v.wd : 8'h00);
    chk($sformatf("v%0d_frame_idle", idx), frame_active, 1'b0);
  endtask

  vec_t vecs[11];
  vec_t hv;

  initial begin
    logic [7:0] rx;
    logic s;
    int p0, diff;

    vecs[0]  = '{8'h80, 2'd1, 24'h000000, 8'h00, 24'hA50000, 48'h0000_0000_0000, 4'd0, 7'h00, 8'h00};
    vecs[1]  = '{8'h02, 2'd1, 24'h5C0000, 8'h00, 24'h000000, 48'h0000_0000_005C, 4'd1, 7'h02, 8'h5C};
    vecs[2]  = '{8'h03, 2'd3, 24'h112233, 8'h00, 24'h000000, 48'h0000_3322_115C, 4'd3, 7'h05, 8'h33};
    vecs[3]  = '{8'h83, 2'd3, 24'h000000, 8'h00, 24'h112233, 48'h0000_3322_115C, 4'd0, 7'h05, 8'h33};
    vecs[4]  = '{8'h81, 2'd1, 24'h000000, 8'h3C, 24'h3C0000, 48'h0000_3322_115C, 4'd0, 7'h05, 8'h33};
    vecs[5]  = '{8'h01, 2'd1, 24'hFF0000, 8'h3C, 24'h000000, 48'h0000_3322_115C, 4'd0, 7'h05, 8'h33};
    vecs[6]  = '{8'h07, 2'd1, 24'hE10000, 8'h00, 24'h000000, 48'hE100_3322_115C, 4'd1, 7'h07, 8'hE1};
    vecs[7]  = '{8'h86, 2'd3, 24'h000000, 8'h00, 24'h00E100, 48'hE100_3322_115C, 4'd0, 7'h07, 8'hE1};
    vecs[8]  = '{8'h7F, 2'd2, 24'hAABB00, 8'h00, 24'h000000, 48'hE100_3322_115C, 4'd0, 7'h07, 8'hE1};
    vecs[9]  = '{8'hFF, 2'd2, 24'h000000, 8'h00, 24'h00A500, 48'hE100_3322_115C, 4'd0, 7'h07, 8'hE1};
    vecs[10] = '{8'h82, 2'd1, 24'h000000, 8'h00, 24'h5C0000, 48'hE100_3322_115C, 4'd0, 7'h07, 8'hE1};

    spi_cs = 1'b1; spi_clk = 1'b0; spi_sdi = 1'b0; sensor = 8'h00; reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_reg_out", reg_out, 48'h0);
    chk("rst_sdo", spi_sdo, 1'b0);
    chk("rst_frame_active", frame_active, 1'b0);
    chk("rst_wr_pulse", wr_pulse, 1'b0);
    chk("rst_wr_addr", wr_addr, 7'd0);
    chk("rst_wr_data", wr_data, 8'h00);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // partial data byte then cs rise: no write, next frame starts clean
    p0 = pulse_cnt;
    cs_low();
    chk("part_frame_active", frame_active, 1'b1);
    spi_byte(8'h04, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, s);
    cs_high();
    chk("part_reg4", reg_out[23:16], 8'h22);
    chk("part_idle", frame_active, 1'b0);
    chk("part_pulses", pulse_cnt - p0, 0);

    cs_low();
    spi_byte(8'h04, rx);
    spi_byte(8'h77, rx);
    diff = change_cyc - last_rise_cyc;
    chk("wr_latency_1to4", (diff >= 1 && diff <= 4), 1'b1);
    cs_high();
    chk("full_reg_out", reg_out, 48'hE100_3377_115C);
    chk("full_pulses", pulse_cnt - p0, PULSE_EN ? 1 : 0);

    // reset during byte1 with cs held low
    cs_low();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, s);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    chk("rstmid_reg_out", reg_out, 48'h0);
    chk("rstmid_wait_cs", frame_active, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, s);
    spi_byte(8'h66, rx);
    chk("rstmid_sdo", rx, 8'h00);
    chk("rstmid_still_wait", frame_active, 1'b0);
    cs_high();
    chk("rstmid_reg_after", reg_out, 48'h0);
    chk("rstmid_pulses", pulse_cnt - p0, 0);

    hv = '{8'h05, 2'd1, 24'h420000, 8'h00, 24'h000000, 48'h0000_4200_0000, 4'd1, 7'h05, 8'h42};
    run_vec(11, hv);
    hv = '{8'h85, 2'd1, 24'h000000, 8'h00, 24'h420000, 48'h0000_4200_0000, 4'd0, 7'h05, 8'h42};
    run_vec(12, hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
